// File: rtl/clock_switch_ctrl_pkg.sv
// Shared types and parameter checks for the pixel-clock select controller.
// State encodings are fixed because downstream debug taps decode them.
package clock_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_OFF = 2'd1,
    ST_SETTLE   = 2'd2
  } state_t;

  localparam int GUARD_MIN = 1;
  localparam int GUARD_MAX = 255;

  function automatic bit guard_ok(input int g);
    return (g >= GUARD_MIN) && (g <= GUARD_MAX);
  endfunction

  function automatic int guard_width(input int g);
    return $clog2(g + 1);
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_guard_timer.sv
// Loadable down-counter that times each guard interval; zero is combinational.
// Saturates at zero: it never wraps, so an idle timer stays quiet.
module guard_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/clock_switch_ctrl.sv
// Drives the pixel-clock mux select, gating the clock for GUARD_CYCLES before and
// after each change (2G+1 cycles request-to-ack); requests arriving while busy get rej.
module clock_switch_ctrl
  import clock_switch_ctrl_pkg::*;
#(
  parameter int   GUARD_CYCLES = 8,
  parameter logic DEFAULT_SEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic req_sel,
  output logic sel,
  output logic gate_en,
  output logic busy,
  output logic ack,
  output logic rej
);

  localparam int CW = guard_width(GUARD_CYCLES);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);

  if (!guard_ok(GUARD_CYCLES)) begin : g_bad_guard
    $error("clock_switch_ctrl: GUARD_CYCLES out of range 1..255");
  end

  state_t state;
  logic   target;
  logic   tmr_load;
  logic   tmr_zero;

  // Reload on acceptance and again on entering SETTLE.
  always_comb begin
    tmr_load = 1'b0;
    if (state == ST_IDLE && req && (req_sel != sel))
      tmr_load = 1'b1;
    else if (state == ST_GATE_OFF && tmr_zero)
      tmr_load = 1'b1;
  end

  guard_timer #(
    .W (CW)
  ) u_guard_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (GUARD_LOAD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= DEFAULT_SEL;
      target  <= DEFAULT_SEL;
      gate_en <= 1'b1;
      busy    <= 1'b0;
      ack     <= 1'b0;
      rej     <= 1'b0;
    end else begin
      ack <= 1'b0;
      rej <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_sel != sel) begin
              state   <= ST_GATE_OFF;
              target  <= req_sel;
              gate_en <= 1'b0;
              busy    <= 1'b1;
            end else begin
              ack <= 1'b1;
            end
          end
        end
        ST_GATE_OFF: begin
          rej <= req;
          if (tmr_zero) begin
            state <= ST_SETTLE;
            sel   <= target;
          end
        end
        ST_SETTLE: begin
          // The completing cycle reports ack only, so ack and rej stay exclusive.
          if (tmr_zero) begin
            state   <= ST_IDLE;
            gate_en <= 1'b1;
            busy    <= 1'b0;
            ack     <= 1'b1;
          end else begin
            rej <= req;
          end
        end
        default: begin
          state   <= ST_IDLE;
          gate_en <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl: directed scenarios then random traffic, all checked
// against a timestamp-based model of the switch sequence.
module tb_clock_switch_ctrl;

  localparam int   G   = 8;
  localparam logic DEF = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic req_sel = 1'b0;
  logic sel, gate_en, busy, ack, rej;

  clock_switch_ctrl #(
    .GUARD_CYCLES (G),
    .DEFAULT_SEL  (DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_sel (req_sel),
    .sel     (sel),
    .gate_en (gate_en),
    .busy    (busy),
    .ack     (ack),
    .rej     (rej)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int last_ack_cyc = -1;

  // Model: a switch accepted in cycle t_acc occupies cycles t_acc+1..t_acc+2G.
  bit   m_active = 0;
  int   t_acc    = 0;
  logic m_tgt    = 1'b0;
  logic m_sel    = DEF;
  bit   exp_vld  = 0;
  logic exp_sel, exp_gate, exp_busy, exp_ack, exp_rej;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
  endtask

  task automatic model_step(input logic r, input logic q, input logic s);
    exp_ack = 1'b0;
    exp_rej = 1'b0;
    if (r) begin
      m_active = 0;
      m_sel    = DEF;
    end else if (m_active) begin
      if (cyc_n == t_acc + 2 * G) begin
        m_active = 0;
        m_sel    = m_tgt;
        exp_ack  = 1'b1;
      end else if (q) begin
        exp_rej = 1'b1;
      end
    end else if (q) begin
      if (s != m_sel) begin
        m_active = 1;
        t_acc    = cyc_n;
        m_tgt    = s;
      end else begin
        exp_ack = 1'b1;
      end
    end
    exp_gate = !m_active;
    exp_busy = m_active;
    exp_sel  = (m_active && (cyc_n + 1 > t_acc + G)) ? m_tgt : m_sel;
    exp_vld  = 1;
  endtask

  task automatic cyc(input logic r, input logic q, input logic s);
    @(negedge clk);
    if (exp_vld) begin
      check("sel", 32'(sel), 32'(exp_sel));
      check("gate_en", 32'(gate_en), 32'(exp_gate));
      check("busy", 32'(busy), 32'(exp_busy));
      check("ack", 32'(ack), 32'(exp_ack));
      check("rej", 32'(rej), 32'(exp_rej));
      check("ack_rej_excl", 32'(ack & rej), 32'd0);
      if (ack === 1'b1) last_ack_cyc = cyc_n;
    end
    rst = r;
    req = q;
    req_sel = s;
    model_step(r, q, s);
    @(posedge clk);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  int acc_cyc;

  initial begin
    // Reset, then release with outputs at defaults.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    idle(2);

    // Full 0->1 switch; ack lands 2G+1 cycles after acceptance.
    acc_cyc = cyc_n;
    cyc(1'b0, 1'b1, 1'b1);
    idle(2 * G + 3);
    check("ack_latency_switch", 32'(last_ack_cyc - acc_cyc), 32'(2 * G + 1));

    // Request for the current select acks next cycle without gating.
    acc_cyc = cyc_n;
    cyc(1'b0, 1'b1, 1'b1);
    idle(2);
    check("ack_latency_same", 32'(last_ack_cyc - acc_cyc), 32'd1);

    // Extra request mid-switch is rejected; original completes.
    cyc(1'b0, 1'b1, 1'b0);
    idle(4);
    cyc(1'b0, 1'b1, 1'b1);
    idle(2 * G + 2);

    // Reset mid-switch aborts it with no ack.
    cyc(1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1);
    idle(11);
    cyc(1'b1, 1'b0, 1'b0);
    idle(2 * G + 4);

    // Back-to-back: new request in the ack cycle is accepted.
    cyc(1'b0, 1'b1, 1'b1);
    idle(2 * G);
    acc_cyc = cyc_n;
    cyc(1'b0, 1'b1, 1'b0);
    idle(2 * G + 2);
    check("ack_latency_b2b", 32'(last_ack_cyc - acc_cyc), 32'(2 * G + 1));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)));
    end
    idle(2 * G + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
